fetch_unit: RTL and testbench

- Initiator side of the byte-addressed, big-endian instruction-memory read interface: owns the PC, drives the fetch address and captures the returned 32-bit word.
- Holds the captured word in an IF/ID register with a valid flag.
- Accepts stall, branch, jump and halt controls from decode/control.
- Sits between the instruction memory and the decode stage of the MIPS-subset core.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// MIPS-subset instruction fetch: owns the PC, reads big-endian words, holds the IF/ID register.
// Capture is one edge after issue; redirects cost one bubble. Build with FETCH_ALIGN_CHECK_EN to trap misaligned targets.
module fetch_unit #(
    parameter int unsigned            PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                halt,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [15:0]         branch_offset,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_instr,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic                if_valid,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [PC_WIDTH-1:0]   ifpc_q, ifpc_d;
    logic                  valid_q, valid_d;

    logic [PC_WIDTH-1:0]   jmp_tgt;
    logic [PC_WIDTH-1:0]   br_tgt;
    logic [PC_WIDTH-1:0]   redir_tgt;

    // Branches are relative to the instruction being decoded, not to the PC now in flight.
    assign jmp_tgt   = PC_WIDTH'({jump_target, 2'b00});
    assign br_tgt    = ifpc_q + PC_WIDTH'(4) + PC_WIDTH'($signed({branch_offset, 2'b00}));
    assign redir_tgt = jump ? jmp_tgt : br_tgt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    state_d = (pc_q[1:0] != 2'b00) ? S_ERR : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_HALT;
                    valid_d = 1'b0;
                end else if (jump || branch_taken) begin
                    // The word fetched this cycle belongs to the wrong path and is dropped.
                    valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (redir_tgt[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        pc_d = redir_tgt;
                    end
`else
                    pc_d = redir_tgt;
`endif
                end else if (!stall) begin
                    instr_d = imem_instr;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_WIDTH'(4);
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_instr  = instr_q;
    assign if_pc     = ifpc_q;
    assign if_valid  = valid_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Three fetch units (RESET_PC 0x00, 0xF8, 0x02) share one stimulus stream; a queue scoreboard checks every cycle.
module tb_fetch_unit;

    localparam int NI = 3;
    localparam logic [NI-1:0][7:0] RPC = {8'h02, 8'hF8, 8'h00};
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt, stall, branch_taken, jump;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;

    logic [7:0]  mem [256];

    logic [NI-1:0][7:0]  addr_w;
    logic [NI-1:0][31:0] imem_w;
    logic [NI-1:0][31:0] ifi_w;
    logic [NI-1:0][7:0]  ifpc_w;
    logic [NI-1:0]       ifv_w;
    logic [NI-1:0][1:0]  st_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign imem_w[g] = {mem[addr_w[g]], mem[addr_w[g] + 8'd1],
                            mem[addr_w[g] + 8'd2], mem[addr_w[g] + 8'd3]};
        fetch_unit #(.PC_WIDTH(8), .RESET_PC(RPC[g])) u_dut (
            .clk           (clk),
            .rst           (rst),
            .start         (start),
            .halt          (halt),
            .stall         (stall),
            .branch_taken  (branch_taken),
            .branch_offset (branch_offset),
            .jump          (jump),
            .jump_target   (jump_target),
            .imem_addr     (addr_w[g]),
            .imem_instr    (imem_w[g]),
            .if_instr      (ifi_w[g]),
            .if_pc         (ifpc_w[g]),
            .if_valid      (ifv_w[g]),
            .state_o       (st_w[g])
        );
    end

    // Reference model: 0 idle, 1 run, 2 halt, 3 error; PCs are plain integers in 0..255.
    int          m_st   [NI];
    int          m_pc   [NI];
    int          m_ifpc [NI];
    logic [31:0] m_ifi  [NI];
    bit          m_ifv  [NI];

    typedef struct packed {
        logic [NI-1:0][1:0]  st;
        logic [NI-1:0][7:0]  addr;
        logic [NI-1:0][7:0]  ifpc;
        logic [NI-1:0][31:0] ifi;
        logic [NI-1:0]       ifv;
    } exp_t;

    exp_t q[$];
    bit   started = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [31:0] word_at(int a);
        return {mem[a & 255], mem[(a + 1) & 255], mem[(a + 2) & 255], mem[(a + 3) & 255]};
    endfunction

    task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] at %0t: got %h, expected %h", name, inst, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_st[i]   = 0;
            m_pc[i]   = int'(RPC[i]);
            m_ifpc[i] = 0;
            m_ifi[i]  = 32'h0;
            m_ifv[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        int t;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NI; i++) begin
            case (m_st[i])
                0: if (start) m_st[i] = (ALIGN && (m_pc[i] % 4 != 0)) ? 3 : 1;
                1: begin
                    if (halt) begin
                        m_st[i]  = 2;
                        m_ifv[i] = 1'b0;
                    end else if (jump || branch_taken) begin
                        if (jump) t = (int'(jump_target) * 4) & 255;
                        else      t = (m_ifpc[i] + 4 + 4 * int'($signed(branch_offset))) & 255;
                        m_ifv[i] = 1'b0;
                        if (ALIGN && (t % 4 != 0)) m_st[i] = 3;
                        else                       m_pc[i] = t;
                    end else if (!stall) begin
                        m_ifi[i]  = word_at(m_pc[i]);
                        m_ifpc[i] = m_pc[i];
                        m_ifv[i]  = 1'b1;
                        m_pc[i]   = (m_pc[i] + 4) & 255;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e = '0;
        for (int i = 0; i < NI; i++) begin
            e.st[i]   = 2'(m_st[i]);
            e.addr[i] = 8'(m_pc[i]);
            e.ifpc[i] = 8'(m_ifpc[i]);
            e.ifi[i]  = m_ifi[i];
            e.ifv[i]  = m_ifv[i];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        q.push_back(snapshot());
        started = 1'b1;
        #1;
    endtask

    // Reset lands mid-cycle; outputs must already be back at reset values before the next edge.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("arst_addr",  i, 32'(addr_w[i]), 32'(RPC[i]));
            chk("arst_instr", i, ifi_w[i], 32'h0);
            chk("arst_ifpc",  i, 32'(ifpc_w[i]), 32'h0);
            chk("arst_valid", i, 32'(ifv_w[i]), 32'h0);
            chk("arst_state", i, 32'(st_w[i]), 32'h0);
        end
        model_reset();
        if (q.size() > 0) void'(q.pop_back());
        q.push_back(snapshot());
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow at %0t: got empty queue, expected an entry", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                for (int i = 0; i < NI; i++) begin
                    chk("state",    i, 32'(st_w[i]),   32'(e.st[i]));
                    chk("imem_addr", i, 32'(addr_w[i]), 32'(e.addr[i]));
                    chk("if_pc",    i, 32'(ifpc_w[i]), 32'(e.ifpc[i]));
                    chk("if_valid", i, 32'(ifv_w[i]),  32'(e.ifv[i]));
                    chk("if_instr", i, ifi_w[i],       e.ifi[i]);
                end
            end
        end
    end

    task automatic clear_inputs();
        start = 1'b0; halt = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_offset = 16'h0; jump_target = 26'h0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        rst = 1'b0;
        clear_inputs();
        model_reset();
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("reset_addr",  i, 32'(addr_w[i]), 32'(RPC[i]));
            chk("reset_valid", i, 32'(ifv_w[i]), 32'h0);
            chk("reset_state", i, 32'(st_w[i]), 32'h0);
        end
        tick();
        tick();
        rst = 1'b0;

        // Sequential fetch and PC wrap
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_edge_valid", 0, 32'(ifv_w[0]), 32'h0);
        tick();
        chk("seq_pc0", 0, 32'(ifpc_w[0]), 32'h00);
        chk("seq_valid0", 0, 32'(ifv_w[0]), 32'h1);
        chk("seq_instr0", 0, ifi_w[0], word_at(0));
        chk("wrap_pc0", 1, 32'(ifpc_w[1]), 32'hF8);
        if (ALIGN) begin
            chk("misalign_state", 2, 32'(st_w[2]), 32'h3);
            chk("misalign_valid", 2, 32'(ifv_w[2]), 32'h0);
        end else begin
            chk("misalign_pc0", 2, 32'(ifpc_w[2]), 32'h02);
            chk("misalign_instr0", 2, ifi_w[2], word_at(2));
        end
        tick();
        chk("seq_pc1", 0, 32'(ifpc_w[0]), 32'h04);
        chk("wrap_pc1", 1, 32'(ifpc_w[1]), 32'hFC);
        if (!ALIGN) chk("misalign_pc1", 2, 32'(ifpc_w[2]), 32'h06);
        tick();
        chk("seq_pc2", 0, 32'(ifpc_w[0]), 32'h08);
        chk("wrap_pc2", 1, 32'(ifpc_w[1]), 32'h00);

        // Forward branch from 0x08
        branch_taken = 1'b1; branch_offset = 16'h0001;
        tick();
        branch_taken = 1'b0;
        chk("br_fwd_bubble", 0, 32'(ifv_w[0]), 32'h0);
        tick();
        chk("br_fwd_pc", 0, 32'(ifpc_w[0]), 32'h10);
        chk("br_fwd_valid", 0, 32'(ifv_w[0]), 32'h1);

        // Jump back to 0x08, then backward branch
        jump = 1'b1; jump_target = 26'h2;
        tick();
        jump = 1'b0;
        tick();
        chk("jmp_pc", 0, 32'(ifpc_w[0]), 32'h08);
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        tick();
        branch_taken = 1'b0;
        chk("br_back_bubble", 0, 32'(ifv_w[0]), 32'h0);
        tick();
        chk("br_back_pc", 0, 32'(ifpc_w[0]), 32'h04);

        // Run to 0x28 then jump whose target wraps to 0
        repeat (9) tick();
        chk("run_pc28", 0, 32'(ifpc_w[0]), 32'h28);
        jump = 1'b1; jump_target = 26'h100;
        tick();
        jump = 1'b0;
        chk("jwrap_addr", 0, 32'(addr_w[0]), 32'h00);
        chk("jwrap_bubble", 0, 32'(ifv_w[0]), 32'h0);
        tick();
        chk("jwrap_pc", 0, 32'(ifpc_w[0]), 32'h00);
        chk("jwrap_valid", 0, 32'(ifv_w[0]), 32'h1);

        // Stall holds everything; a redirect overrides a stall
        stall = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_pc", 0, 32'(ifpc_w[0]), 32'h00);
            chk("stall_addr", 0, 32'(addr_w[0]), 32'h04);
            chk("stall_instr", 0, ifi_w[0], word_at(0));
        end
        branch_taken = 1'b1; branch_offset = 16'h0002;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        chk("stall_br_bubble", 0, 32'(ifv_w[0]), 32'h0);
        chk("stall_br_addr", 0, 32'(addr_w[0]), 32'h0C);
        tick();
        chk("stall_br_pc", 0, 32'(ifpc_w[0]), 32'h0C);

        // Halt is terminal regardless of controls
        halt = 1'b1;
        tick();
        halt = 1'b0;
        start = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        repeat (4) begin
            tick();
            chk("halt_state", 0, 32'(st_w[0]), 32'h2);
            chk("halt_valid", 0, 32'(ifv_w[0]), 32'h0);
            chk("halt_addr", 0, 32'(addr_w[0]), 32'h10);
        end
        clear_inputs();
        async_reset();

        // Randomised phase with periodic mid-cycle resets
        for (int c = 0; c < 1500; c++) begin
            if (c % 120 == 0) begin
                clear_inputs();
                async_reset();
                start = 1'b1;
                tick();
            end
            start         = ($urandom_range(0, 3) == 0);
            halt          = ($urandom_range(0, 199) == 0);
            jump          = ($urandom_range(0, 15) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_offset = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) - 16'd8
                                                        : 16'($urandom);
            jump_target   = 26'($urandom);
            tick();
        end
        clear_inputs();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
